// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// FSM state encodings, data-port op codes (NONE is the idle/default op),
// and byte-strobe patterns used when RAM_BYTE_STROBE_EN is defined.
package ram_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RMW_RD  = 3'd2,
    ST_RMW_WR  = 3'd3,
    ST_WR      = 3'd4,
    ST_NOP_ACK = 3'd5
  } state_e;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_store_merge.sv
// ram_store_merge: combinational read-modify-write merge for sub-word stores.
// SB replaces the byte at offset[1:0]; SH replaces the half at offset[1]
// (offset[0] ignored); SW returns the store word; other ops pass old_i.
module ram_store_merge
  import ram_port_arbiter_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] old_i,
  input  logic [31:0] data_i,
  output logic [31:0] merged_o
);

  // Overlay the right-aligned store data onto the selected lane(s).
  always_comb begin
    merged_o = old_i;
    case (op_i)
      OP_SB: begin
        case (offset_i)
          2'd0:    merged_o[7:0]   = data_i[7:0];
          2'd1:    merged_o[15:8]  = data_i[7:0];
          2'd2:    merged_o[23:16] = data_i[7:0];
          default: merged_o[31:24] = data_i[7:0];
        endcase
      end
      OP_SH: begin
        if (offset_i[1]) merged_o[31:16] = data_i[15:0];
        else             merged_o[15:0]  = data_i[15:0];
      end
      OP_SW:   merged_o = data_i;
      default: merged_o = old_i;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: arbitrates fetch and data requesters onto one RAM port.
// Data has priority unless the previous grant went to data and fetch is
// waiting. Commands and acks are registered; read data is passed through
// combinationally while the owner's ack is high.
// Optional feature macro: RAM_BYTE_STROBE_EN (adds ram_be_o; sub-word stores
// become single strobed writes instead of read-modify-write).
// Handshake: a requester raises req with its operands and holds them until
// it sees its one-cycle ack; operands are latched at grant, and no new grant
// is made in an ack cycle, so a held req is never served twice.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_ack_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  d_req_i,
  input  logic [3:0]            d_op_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_ack_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
`ifdef RAM_BYTE_STROBE_EN
  output logic [3:0]            ram_be_o,
`endif
  output logic [2:0]            dbg_state_o
);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_e                state_q, state_d;
  logic                  last_data_q, last_data_d;  // 1: last grant (and current owner) is data
  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  if_ack_q, if_ack_d;
  logic                  d_ack_q, d_ack_d;
`ifdef RAM_BYTE_STROBE_EN
  logic [3:0]            ram_be_q, ram_be_d;
`else
  logic [3:0]            op_q, op_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] st_data_q, st_data_d;
  logic [DATA_WIDTH-1:0] merged;
`endif

  logic ack_cycle, gnt_data, gnt_fetch;
  assign ack_cycle = if_ack_q | d_ack_q;
  assign gnt_data  = d_req_i & (~if_req_i | ~last_data_q);
  assign gnt_fetch = if_req_i & ~gnt_data;

  // Next-state and next registered command/ack values.
  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
`ifdef RAM_BYTE_STROBE_EN
    ram_be_d    = 4'b0000;
`else
    op_d        = op_q;
    off_d       = off_q;
    st_data_d   = st_data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!ack_cycle && gnt_data) begin
          last_data_d = 1'b1;
`ifndef RAM_BYTE_STROBE_EN
          op_d      = d_op_i;
          off_d     = d_addr_i[1:0];
          st_data_d = d_wdata_i;
`endif
          if (op_is_load(d_op_i)) begin
            ram_en_d   = 1'b1;
            ram_addr_d = d_addr_i & WORD_MASK;
`ifdef RAM_BYTE_STROBE_EN
            ram_be_d   = BE_ALL;
`endif
            state_d    = ST_RD;
          end else if (d_op_i == OP_SW) begin
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = d_addr_i & WORD_MASK;
            ram_wdata_d = d_wdata_i;
`ifdef RAM_BYTE_STROBE_EN
            ram_be_d    = BE_ALL;
`endif
            d_ack_d     = 1'b1;
            state_d     = ST_WR;
          end else if ((d_op_i == OP_SB) || (d_op_i == OP_SH)) begin
            ram_en_d   = 1'b1;
            ram_addr_d = d_addr_i & WORD_MASK;
`ifdef RAM_BYTE_STROBE_EN
            ram_we_d = 1'b1;
            if (d_op_i == OP_SB) begin
              ram_wdata_d = {4{d_wdata_i[7:0]}};
              ram_be_d    = BE_BYTE0 << d_addr_i[1:0];
            end else begin
              ram_wdata_d = {2{d_wdata_i[15:0]}};
              ram_be_d    = d_addr_i[1] ? BE_HI_HALF : BE_LO_HALF;
            end
            d_ack_d = 1'b1;
            state_d = ST_WR;
`else
            state_d = ST_RMW_RD;
`endif
          end else begin
            d_ack_d = 1'b1;
            state_d = ST_NOP_ACK;
          end
        end else if (!ack_cycle && gnt_fetch) begin
          last_data_d = 1'b0;
          ram_en_d    = 1'b1;
          ram_addr_d  = if_addr_i & WORD_MASK;
`ifdef RAM_BYTE_STROBE_EN
          ram_be_d    = BE_ALL;
`endif
          state_d     = ST_RD;
        end
      end
      ST_RD: begin
        if (last_data_q) d_ack_d  = 1'b1;
        else             if_ack_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RMW_RD: begin
        // Old word arrives next cycle; the merged write goes out with it.
        ram_en_d   = 1'b1;
        ram_we_d   = 1'b1;
        ram_addr_d = ram_addr_q;
        d_ack_d    = 1'b1;
        state_d    = ST_RMW_WR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched operands and registered RAM command / ack outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      last_data_q <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
`ifdef RAM_BYTE_STROBE_EN
      ram_be_q    <= 4'b0000;
`else
      op_q        <= OP_NONE;
      off_q       <= 2'd0;
      st_data_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
`ifdef RAM_BYTE_STROBE_EN
      ram_be_q    <= ram_be_d;
`else
      op_q        <= op_d;
      off_q       <= off_d;
      st_data_q   <= st_data_d;
`endif
    end
  end

`ifdef RAM_BYTE_STROBE_EN
  assign ram_wdata_o = ram_wdata_q;
  assign ram_be_o    = ram_be_q;
`else
  ram_store_merge u_merge (
    .op_i     (op_q),
    .offset_i (off_q),
    .old_i    (ram_rdata_i),
    .data_i   (st_data_q),
    .merged_o (merged)
  );
  // The old word is only available in the write cycle, so the merged word is
  // steered onto the write bus there; all other writes come from the register.
  assign ram_wdata_o = (state_q == ST_RMW_WR) ? merged : ram_wdata_q;
`endif

  assign ram_en_o    = ram_en_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign if_rdata_o  = if_ack_q ? ram_rdata_i : '0;
  assign d_rdata_o   = d_ack_q ? ram_rdata_i : '0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter with a behavioural single-port RAM.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_op;
  logic        if_ack, d_ack, ram_en, ram_we;
  logic [31:0] if_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_be;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // RAM model and preload port
  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_idx;
  logic [31:0] pre_data;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_ack_o    (if_ack),
    .if_rdata_o  (if_rdata),
    .d_req_i     (d_req),
    .d_op_i      (d_op),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_ack_o     (d_ack),
    .d_rdata_o   (d_rdata),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
`ifdef RAM_BYTE_STROBE_EN
    .ram_be_o    (ram_be),
`endif
    .dbg_state_o (dbg_state)
  );

`ifndef RAM_BYTE_STROBE_EN
  assign ram_be = 4'b1111;
`endif

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[11:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[11:2]];
      end
    end
  end

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    pre_idx = idx; pre_data = data; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; if_req = 0; d_req = 0; if_addr = 0; d_addr = 0; d_wdata = 0; d_op = OP_NONE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", ram_en); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", ram_we); end
    checks++; if (ram_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", ram_addr); end
    checks++; if (if_ack !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL reset_acks: got if=%b d=%b expected 0 0", if_ack, d_ack); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_fetch;
    preload(10'h41, 32'hDEADBEEF);
    if_addr = 32'h104; if_req = 1'b1;
    @(negedge clk);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL fetch_n_en: got %b expected 0", ram_en); end
    @(negedge clk);
    checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL fetch_cmd: got en=%b we=%b expected 1 0", ram_en, ram_we); end
    checks++; if (ram_addr !== 32'h104) begin errors++; $display("FAIL fetch_addr: got %h expected 00000104", ram_addr); end
    checks++; if (if_ack !== 1'b0) begin errors++; $display("FAIL fetch_early_ack: got %b expected 0", if_ack); end
    @(negedge clk);
    checks++; if (if_ack !== 1'b1) begin errors++; $display("FAIL fetch_ack: got %b expected 1", if_ack); end
    checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata: got %h expected deadbeef", if_rdata); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL fetch_ack_en: got %b expected 0", ram_en); end
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    checks++; if (if_ack !== 1'b0) begin errors++; $display("FAIL fetch_single_ack: got %b expected 0", if_ack); end
  endtask

  task automatic test_sw_lw;
    @(posedge clk); #1;
    d_op = OP_SW; d_addr = 32'h300; d_wdata = 32'h12345678; d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ram_en !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL sw_cmd: got en=%b we=%b expected 1 1", ram_en, ram_we); end
    checks++; if (ram_addr !== 32'h300) begin errors++; $display("FAIL sw_addr: got %h expected 00000300", ram_addr); end
    checks++; if (ram_wdata !== 32'h12345678) begin errors++; $display("FAIL sw_wdata: got %h expected 12345678", ram_wdata); end
    checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL sw_ack: got %b expected 1", d_ack); end
    @(posedge clk); #1;
    d_op = OP_LW; d_wdata = 32'h0;
    @(negedge clk);
    checks++; if (mem[10'hC0] !== 32'h12345678) begin errors++; $display("FAIL sw_mem: got %h expected 12345678", mem[10'hC0]); end
    @(negedge clk);
    checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h300) begin errors++; $display("FAIL lw_cmd: got en=%b we=%b addr=%h expected 1 0 00000300", ram_en, ram_we, ram_addr); end
    @(negedge clk);
    checks++; if (d_ack !== 1'b1 || d_rdata !== 32'h12345678) begin errors++; $display("FAIL lw_data: got ack=%b data=%h expected 1 12345678", d_ack, d_rdata); end
    @(posedge clk); #1 d_req = 1'b0;
    @(negedge clk);
    checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL lw_single_ack: got %b expected 0", d_ack); end
  endtask

  // Sub-word store: expected word written and lane strobes in the strobe build.
  task automatic run_substore(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_word, input logic [31:0] exp_strobe_data,
                              input logic [3:0] exp_be, input string name);
    preload(addr[11:2], 32'h11223344);
    d_op = op; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
`ifdef RAM_BYTE_STROBE_EN
    checks++; if (ram_we !== 1'b1 || d_ack !== 1'b1 || ram_be !== exp_be || ram_wdata !== exp_strobe_data)
      begin errors++; $display("FAIL %s_strobe_wr: got we=%b ack=%b be=%b data=%h expected 1 1 %b %h", name, ram_we, d_ack, ram_be, ram_wdata, exp_be, exp_strobe_data); end
`else
    checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL %s_rmw_rd: got en=%b we=%b ack=%b expected 1 0 0", name, ram_en, ram_we, d_ack); end
    checks++; if (ram_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL %s_rd_addr: got %h expected %h", name, ram_addr, {addr[31:2], 2'b00}); end
    @(posedge clk); #1;
    d_wdata = 32'hFFFFFFFF; d_addr = 32'h0;
    @(negedge clk);
    checks++; if (ram_en !== 1'b1 || ram_we !== 1'b1 || d_ack !== 1'b1) begin errors++; $display("FAIL %s_rmw_wr: got en=%b we=%b ack=%b expected 1 1 1", name, ram_en, ram_we, d_ack); end
    checks++; if (ram_wdata !== exp_word) begin errors++; $display("FAIL %s_merge: got %h expected %h", name, ram_wdata, exp_word); end
`endif
    @(posedge clk); #1 d_req = 1'b0;
    @(negedge clk);
    checks++; if (mem[addr[11:2]] !== exp_word) begin errors++; $display("FAIL %s_mem: got %h expected %h", name, mem[addr[11:2]], exp_word); end
    checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL %s_single_ack: got %b expected 0", name, d_ack); end
  endtask

  task automatic test_sub_stores;
    run_substore(OP_SB, 32'h202, 32'h000000AB, 32'h11AB3344, 32'hABABABAB, 4'b0100, "sb");
    run_substore(OP_SH, 32'h206, 32'h0000CAFE, 32'hCAFE3344, 32'hCAFECAFE, 4'b1100, "sh206");
    run_substore(OP_SH, 32'h207, 32'h0000CAFE, 32'hCAFE3344, 32'hCAFECAFE, 4'b1100, "sh207");
  endtask

  task automatic test_collision;
    // lone fetch so that the last grant is fetch
    @(posedge clk); #1;
    if_addr = 32'h104; if_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (if_ack !== 1'b1) begin errors++; $display("FAIL coll_pre_fetch: got %b expected 1", if_ack); end
    @(posedge clk); #1 if_req = 1'b0;
    @(posedge clk); #1;
    d_op = OP_LW; d_addr = 32'h300; if_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ram_addr !== 32'h300) begin errors++; $display("FAIL coll1_winner: got %h expected 00000300", ram_addr); end
    @(negedge clk);
    checks++; if (d_ack !== 1'b1 || if_ack !== 1'b0 || d_rdata !== 32'h12345678) begin errors++; $display("FAIL coll1_ack: got d=%b if=%b data=%h expected 1 0 12345678", d_ack, if_ack, d_rdata); end
    @(posedge clk); #1;
    d_addr = 32'h200;
    @(negedge clk);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL coll2_grant_cycle: got %b expected 0", ram_en); end
    @(negedge clk);
    checks++; if (ram_addr !== 32'h104 || ram_en !== 1'b1) begin errors++; $display("FAIL coll2_winner: got en=%b addr=%h expected 1 00000104", ram_en, ram_addr); end
    @(negedge clk);
    checks++; if (if_ack !== 1'b1 || d_ack !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL coll2_ack: got if=%b d=%b data=%h expected 1 0 deadbeef", if_ack, d_ack, if_rdata); end
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ram_addr !== 32'h200) begin errors++; $display("FAIL coll3_addr: got %h expected 00000200", ram_addr); end
    @(negedge clk);
    checks++; if (d_ack !== 1'b1 || d_rdata !== 32'h11AB3344) begin errors++; $display("FAIL coll3_ack: got ack=%b data=%h expected 1 11ab3344", d_ack, d_rdata); end
    @(posedge clk); #1 d_req = 1'b0;
  endtask

  task automatic test_nop;
    logic [3:0] ops [2];
    ops[0] = OP_NONE; ops[1] = 4'hC;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      d_op = ops[i]; d_addr = 32'h300; d_wdata = 32'hFFFFFFFF; d_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (d_ack !== 1'b1 || ram_en !== 1'b0) begin errors++; $display("FAIL nop_ack_op%0h: got ack=%b en=%b expected 1 0", ops[i], d_ack, ram_en); end
      @(posedge clk); #1 d_req = 1'b0;
      @(negedge clk);
      checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL nop_single_ack_op%0h: got %b expected 0", ops[i], d_ack); end
    end
    checks++; if (mem[10'hC0] !== 32'h12345678) begin errors++; $display("FAIL nop_mem: got %h expected 12345678", mem[10'hC0]); end
  endtask

  task automatic test_reset_rmw;
    preload(10'h80, 32'hA5A5A5A5);
    d_op = OP_SB; d_addr = 32'h201; d_wdata = 32'h5A; d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
`ifndef RAM_BYTE_STROBE_EN
    @(negedge clk);
`endif
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rst_pre_write: got %b expected 1", ram_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL rst_abort: got en=%b we=%b expected 0 0", ram_en, ram_we); end
    checks++; if (d_ack !== 1'b0 || dbg_state !== 3'd0) begin errors++; $display("FAIL rst_no_ack: got ack=%b state=%0d expected 0 0", d_ack, dbg_state); end
    @(posedge clk); #1 d_req = 1'b0;
    @(negedge clk);
    checks++; if (mem[10'h80] !== 32'hA5A5A5A5) begin errors++; $display("FAIL rst_mem: got %h expected a5a5a5a5", mem[10'h80]); end
    rst_n = 1'b1;
    // last grant reset to fetch: a collision now goes to data
    @(posedge clk); #1;
    d_op = OP_LW; d_addr = 32'h300; if_addr = 32'h104; d_req = 1'b1; if_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ram_addr !== 32'h300 || ram_en !== 1'b1) begin errors++; $display("FAIL rst_coll_winner: got en=%b addr=%h expected 1 00000300", ram_en, ram_addr); end
    @(negedge clk);
    checks++; if (d_ack !== 1'b1 || d_rdata !== 32'h12345678) begin errors++; $display("FAIL rst_load: got ack=%b data=%h expected 1 12345678", d_ack, d_rdata); end
    @(posedge clk); #1 d_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (if_ack !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_fetch: got ack=%b data=%h expected 1 deadbeef", if_ack, if_rdata); end
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_sw_lw();
    test_sub_stores();
    test_collision();
    test_nop();
    test_reset_rmw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
